// File: rtl/klein80_seq_ctrl.sv
// ============================================================================
// klein80_seq_ctrl : job sequencer streaming key/plaintext bytes into a
//                    byte-serial klein_80 core and collecting its ciphertext.
// Revision 1.0
// ============================================================================
`default_nettype none

module klein80_seq_ctrl #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TO_W    = 10
) (
  input  logic        ck_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [63:0] req_pt_i,
  input  logic [79:0] req_key_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_ct_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        core_start_o,
  output logic [7:0]  core_inp_o,
  output logic [7:0]  core_key_o,
  input  logic        core_ready_i,
  input  logic [7:0]  core_out_i
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WAIT   = 3'd2,
    S_UNLOAD = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] WD_ONE  = TO_W'(1);

  state_e          state_q, state_d;
  logic [63:0]     pt_q, pt_d;
  logic [79:0]     key_q, key_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [63:0]     ct_q, ct_d;
  logic            err_q, err_d;
  logic            start_q, start_d;
  logic [7:0]      inp_q, inp_d;
  logic [7:0]      kb_q, kb_d;
  logic            rdy_q;

  logic            req_ready;
  logic            accept;
  logic            rdy_evt;
  logic            wd_exp;

  assign req_ready = (state_q == S_IDLE) && !rst_i;
  assign accept    = req_valid_i && req_ready;
  // Only a fresh rising edge counts; a level left high by an earlier job is ignored.
  assign rdy_evt   = core_ready_i && !rdy_q;
  assign wd_exp    = (wd_q >= WD_LAST);

  always_comb begin
    state_d = state_q;
    pt_d    = pt_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    ct_d    = ct_q;
    err_d   = err_q;
    start_d = 1'b0;
    inp_d   = inp_q;
    kb_d    = kb_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          // Byte 0 goes straight to the core outputs; the rest wait in shift registers.
          state_d = S_LOAD;
          inp_d   = req_pt_i[63:56];
          kb_d    = req_key_i[79:72];
          pt_d    = {req_pt_i[55:0], 8'h00};
          key_d   = {req_key_i[71:0], 8'h00};
          start_d = 1'b1;
          cnt_d   = 4'd0;
          ct_d    = 64'h0;
          err_d   = 1'b0;
        end
      end

      S_LOAD: begin
        if (cnt_q == 4'd9) begin
          state_d = S_WAIT;
          inp_d   = 8'h00;
          kb_d    = 8'h00;
          wd_d    = '0;
        end else begin
          inp_d = pt_q[63:56];
          kb_d  = key_q[79:72];
          pt_d  = {pt_q[55:0], 8'h00};
          key_d = {key_q[71:0], 8'h00};
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_WAIT: begin
        if (rdy_evt) begin
          ct_d    = {ct_q[55:0], core_out_i};
          cnt_d   = 4'd1;
          state_d = S_UNLOAD;
        end else if (wd_exp) begin
          ct_d    = 64'h0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end

      S_UNLOAD: begin
        ct_d = {ct_q[55:0], core_out_i};
        if (cnt_q == 4'd7) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ck_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pt_q    <= 64'h0;
      key_q   <= 80'h0;
      cnt_q   <= 4'd0;
      wd_q    <= '0;
      ct_q    <= 64'h0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      inp_q   <= 8'h00;
      kb_q    <= 8'h00;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      ct_q    <= ct_d;
      err_q   <= err_d;
      start_q <= start_d;
      inp_q   <= inp_d;
      kb_q    <= kb_d;
      rdy_q   <= core_ready_i;
    end
  end

  assign req_ready_o  = req_ready;
  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_ct_o     = ct_q;
  assign rsp_err_o    = err_q;
  assign busy_o       = (state_q != S_IDLE);
  assign core_start_o = start_q;
  assign core_inp_o   = inp_q;
  assign core_key_o   = kb_q;

endmodule

`default_nettype wire
